// File: rtl/spi_xfer_pkg.sv
// Shared types for the SPI transfer engine.
// State encoding and the per-word configuration latched on accept.
package spi_xfer_pkg;

    localparam int DIV_MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        GAP
    } state_e;

    typedef struct packed {
        logic                 cpol;
        logic                 cpha;
        logic                 lsb_first;
        logic                 loopback;
        logic [DIV_MAX_W-1:0] div;
    } cfg_t;

endpackage

// File: rtl/spi_xfer_engine_tick.sv
// Half-period tick generator for the SPI engine.
// Counts 0..div_i and restarts from zero when a word is accepted.
module spi_tick_gen
    import spi_xfer_pkg::*;
#(
    parameter int W = DIV_MAX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] div_i,
    input  logic         restart_i,
    output logic         tick_o,
    output logic         pre_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q + W'(1);
        tick_o = (cnt_q == div_i);
        pre_o  = (cnt_d == div_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_xfer_engine.sv
// SPI master transfer engine: one word per valid/ready handshake,
// configurable mode, bit order, clock divider and internal loopback.
module spi_xfer_engine
    import spi_xfer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic              cfg_loopback,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    input  logic              miso
);

    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_E = EW'(2 * DATA_W - 1);

    state_e            state_q;
    cfg_t              cfg_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [EW-1:0]     edge_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic              tx_ready_q;
    logic              rx_valid_q;
    logic              busy_q;

    logic              accept;
    logic              tick;
    logic              pre;
    logic              shift_e;
    logic              in_bit;
    logic              out_bit;
    logic              first_d;
    logic [DATA_W-1:0] load_d;
    logic [DATA_W-1:0] tx_shift_d;
    logic [DATA_W-1:0] rx_ins_d;

    spi_tick_gen #(
        .W(DIV_MAX_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_i    (cfg_q.div),
        .restart_i(accept),
        .tick_o   (tick),
        .pre_o    (pre)
    );

    // Even edge index = leading edge; CPHA picks which edge shifts.
    always_comb begin
        accept     = (state_q == IDLE) && tx_valid && tx_ready_q;
        shift_e    = cfg_q.cpha ? ~edge_q[0] : edge_q[0];
        in_bit     = cfg_q.loopback ? mosi_q : miso;
        out_bit    = cfg_q.lsb_first ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
        tx_shift_d = cfg_q.lsb_first ? {1'b0, tx_sh_q[DATA_W-1:1]}
                                     : {tx_sh_q[DATA_W-2:0], 1'b0};
        rx_ins_d   = cfg_q.lsb_first ? {in_bit, rx_sh_q[DATA_W-1:1]}
                                     : {rx_sh_q[DATA_W-2:0], in_bit};
        first_d    = cfg_lsb_first ? tx_data[0] : tx_data[DATA_W-1];
        load_d     = cfg_lsb_first ? {1'b0, tx_data[DATA_W-1:1]}
                                   : {tx_data[DATA_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            edge_q     <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    sclk_q     <= cfg_cpol;
                    tx_ready_q <= 1'b1;
                    if (accept) begin
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cs_n_q     <= 1'b0;
                        edge_q     <= '0;
                        rx_sh_q    <= '0;
                        cfg_q      <= '{cpol:      cfg_cpol,
                                        cpha:      cfg_cpha,
                                        lsb_first: cfg_lsb_first,
                                        loopback:  cfg_loopback,
                                        div:       DIV_MAX_W'(cfg_div)};
                        tx_sh_q    <= cfg_cpha ? tx_data : load_d;
                        mosi_q     <= cfg_cpha ? mosi_q : first_d;
                        state_q    <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) state_q <= XFER;
                end
                XFER: begin
                    if (tick) begin
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + EW'(1);
                        if (shift_e) begin
                            mosi_q  <= out_bit;
                            tx_sh_q <= tx_shift_d;
                        end else begin
                            rx_sh_q <= rx_ins_d;
                        end
                        if (edge_q == LAST_E) state_q <= TRAIL;
                    end
                end
                TRAIL: begin
                    sclk_q <= cfg_q.cpol;
                    if (tick) begin
                        cs_n_q     <= 1'b1;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sh_q;
                        // The IDLE cycle counts toward the cs_n-high gap.
                        if (cfg_q.div == '0) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            tx_ready_q <= 1'b1;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (pre) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine: 16-bit and 8-bit instances,
// loopback, slave-driven miso, back-to-back, reset abort, cfg latching.
module tb_spi_xfer_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [7:0]  cfg_div = 8'd1;
    logic        cfg_cpol = 1'b0, cfg_cpha = 1'b0;
    logic        cfg_lsb = 1'b0, cfg_lb = 1'b1;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, rx_valid, busy, sclk, mosi, cs_n;
    logic        miso = 1'b1;
    logic [15:0] rx_data;

    logic [7:0]  d8_div = 8'd0, d8_tx = '0;
    logic        d8_zero = 1'b0, d8_one = 1'b1, d8_miso = 1'b0;
    logic        d8_valid = 1'b0;
    logic        d8_ready, d8_rxv, d8_busy, d8_sclk, d8_mosi, d8_cs_n;
    logic [7:0]  d8_rx;

    int tests = 0;
    int fails = 0;

    spi_xfer_engine #(.DATA_W(16), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_lsb_first(cfg_lsb), .cfg_loopback(cfg_lb),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso)
    );

    spi_xfer_engine #(.DATA_W(8), .DIV_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .cfg_div(d8_div),
        .cfg_cpol(d8_zero), .cfg_cpha(d8_zero),
        .cfg_lsb_first(d8_zero), .cfg_loopback(d8_one),
        .tx_data(d8_tx), .tx_valid(d8_valid), .tx_ready(d8_ready),
        .rx_data(d8_rx), .rx_valid(d8_rxv), .busy(d8_busy),
        .sclk(d8_sclk), .mosi(d8_mosi), .cs_n(d8_cs_n), .miso(d8_miso)
    );

    int          cs_low = 0, edges = 0, rises = 0, rxv = 0;
    int          high_run = 0, last_gap = 0;
    logic [15:0] cap_msb = '0, cap_lsb = '0, slv_word = '0;
    logic        slv_en = 1'b0;
    logic [3:0]  slv_idx = '0;
    logic        sclk_p = 1'b0, cs_p = 1'b1;

    // Pin monitor and a simple slave that shifts miso on falling sclk.
    always @(negedge clk) begin
        if (!cs_n) cs_low <= cs_low + 1;
        if (!cs_n && sclk !== sclk_p) begin
            edges <= edges + 1;
            if (sclk) begin
                rises   <= rises + 1;
                cap_msb <= {cap_msb[14:0], mosi};
                cap_lsb <= {mosi, cap_lsb[15:1]};
            end
        end
        if (!slv_en) begin
            miso <= 1'b1;
        end else if (!cs_n && sclk !== sclk_p && !sclk) begin
            miso <= slv_word[slv_idx];
        end
        if (cs_n) slv_idx <= '0;
        else if (sclk !== sclk_p && !sclk) slv_idx <= slv_idx + 4'd1;
        if (rx_valid) rxv <= rxv + 1;
        if (cs_n) begin
            high_run <= high_run + 1;
        end else if (cs_p) begin
            last_gap <= high_run;
            high_run <= 0;
        end
        sclk_p <= sclk;
        cs_p   <= cs_n;
    end

    int   cs8 = 0, edges8 = 0, rxv8 = 0;
    logic s8_p = 1'b0;

    always @(negedge clk) begin
        if (!d8_cs_n) cs8 <= cs8 + 1;
        if (!d8_cs_n && d8_sclk !== s8_p) edges8 <= edges8 + 1;
        if (d8_rxv) rxv8 <= rxv8 + 1;
        s8_p <= d8_sclk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send16(input logic [15:0] w);
        int k;
        k = 0;
        while (!tx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready: tx_ready=%b want 1", tx_ready);
        end
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx16();
        int k;
        k = 0;
        while (!rx_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (rx_valid !== 1'b1) begin
            fails++;
            $display("FAIL rx_timeout: rx_valid=%b want 1", rx_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        tests += 8;
        if (cs_n !== 1'b1) begin fails++; $display("FAIL rst_cs_n: %b want 1", cs_n); end
        if (sclk !== 1'b0) begin fails++; $display("FAIL rst_sclk: %b want 0", sclk); end
        if (mosi !== 1'b0) begin fails++; $display("FAIL rst_mosi: %b want 0", mosi); end
        if (tx_ready !== 1'b0) begin fails++; $display("FAIL rst_tx_ready: %b want 0", tx_ready); end
        if (rx_valid !== 1'b0) begin fails++; $display("FAIL rst_rx_valid: %b want 0", rx_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: %b want 0", busy); end
        if (rx_data !== 16'h0) begin fails++; $display("FAIL rst_rx_data: %h want 0000", rx_data); end
        if (d8_cs_n !== 1'b1) begin fails++; $display("FAIL rst_d8_cs_n: %b want 1", d8_cs_n); end
        rst_n = 1'b1;
        tick(1);
        tests += 2;
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_rise: %b want 1", tx_ready); end
        if (d8_ready !== 1'b1) begin fails++; $display("FAIL rst_d8_ready: %b want 1", d8_ready); end
    endtask

    task automatic test_mode0_loopback();
        int c0, r0, v0;
        cfg_div = 8'd1; cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_lb = 1;
        tick(2);
        c0 = cs_low; r0 = rises; v0 = rxv;
        send16(16'hA55A);
        tests += 3;
        if (busy !== 1'b1) begin fails++; $display("FAIL m0_busy: %b want 1", busy); end
        if (cs_n !== 1'b0) begin fails++; $display("FAIL m0_cs_low: %b want 0", cs_n); end
        if (tx_ready !== 1'b0) begin fails++; $display("FAIL m0_ready_drop: %b want 0", tx_ready); end
        wait_rx16();
        tests++;
        if (rx_data !== 16'hA55A) begin fails++; $display("FAIL m0_rx: %h want a55a", rx_data); end
        tick(4);
        tests += 4;
        if (cs_low - c0 != 68) begin fails++; $display("FAIL m0_cs_cycles: %0d want 68", cs_low - c0); end
        if (rises - r0 != 16) begin fails++; $display("FAIL m0_rises: %0d want 16", rises - r0); end
        if (rxv - v0 != 1) begin fails++; $display("FAIL m0_rxv: %0d want 1", rxv - v0); end
        if (cap_msb !== 16'hA55A) begin fails++; $display("FAIL m0_mosi: %h want a55a", cap_msb); end
    endtask

    task automatic test_mode3_lsb();
        cfg_div = 8'd1; cfg_cpol = 1; cfg_cpha = 1; cfg_lsb = 1; cfg_lb = 0;
        slv_word = 16'h3C96;
        slv_en = 1'b1;
        tick(3);
        tests++;
        if (sclk !== 1'b1) begin fails++; $display("FAIL m3_idle_pre: %b want 1", sclk); end
        send16(16'h1E2D);
        wait_rx16();
        tests++;
        if (rx_data !== 16'h3C96) begin fails++; $display("FAIL m3_rx: %h want 3c96", rx_data); end
        tick(4);
        tests += 2;
        if (cap_lsb !== 16'h1E2D) begin fails++; $display("FAIL m3_mosi_lsb: %h want 1e2d", cap_lsb); end
        if (sclk !== 1'b1) begin fails++; $display("FAIL m3_idle_post: %b want 1", sclk); end
        slv_en = 1'b0;
        cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_lb = 1;
        tick(3);
    endtask

    task automatic test_back_to_back();
        int v0, k;
        cfg_div = 8'd3; cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_lb = 1;
        tick(2);
        v0 = rxv;
        tx_data = 16'h1234;
        tx_valid = 1'b1;
        k = 0;
        while (!busy && k < 50) begin @(negedge clk); k++; end
        tx_data = 16'hBEEF;
        wait_rx16();
        tests++;
        if (rx_data !== 16'h1234) begin fails++; $display("FAIL b2b_rx1: %h want 1234", rx_data); end
        k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end
        k = 0;
        while (!busy && k < 100) begin @(negedge clk); k++; end
        tx_valid = 1'b0;
        tests += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept2: busy=%b want 1", busy); end
        if (rx_data !== 16'h1234) begin fails++; $display("FAIL b2b_hold: %h want 1234", rx_data); end
        wait_rx16();
        tests++;
        if (rx_data !== 16'hBEEF) begin fails++; $display("FAIL b2b_rx2: %h want beef", rx_data); end
        tick(3);
        tests += 2;
        if (last_gap != 4) begin fails++; $display("FAIL b2b_gap: %0d want 4", last_gap); end
        if (rxv - v0 != 2) begin fails++; $display("FAIL b2b_rxv: %0d want 2", rxv - v0); end
        tick(10);
    endtask

    task automatic test_reset_mid();
        int e0, v0, k;
        cfg_div = 8'd1; cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_lb = 1;
        tick(2);
        e0 = edges;
        send16(16'hFFFF);
        k = 0;
        while (edges - e0 < 5 && k < 200) begin @(negedge clk); k++; end
        tests++;
        if (edges - e0 < 5) begin fails++; $display("FAIL mid_edges: %0d want 5", edges - e0); end
        v0 = rxv;
        rst_n = 1'b0;
        tick(1);
        tests += 4;
        if (cs_n !== 1'b1) begin fails++; $display("FAIL mid_cs_n: %b want 1", cs_n); end
        if (sclk !== 1'b0) begin fails++; $display("FAIL mid_sclk: %b want 0", sclk); end
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: %b want 0", busy); end
        if (rx_valid !== 1'b0) begin fails++; $display("FAIL mid_rx_valid: %b want 0", rx_valid); end
        rst_n = 1'b1;
        tick(1);
        tests++;
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: %b want 1", tx_ready); end
        tick(80);
        tests++;
        if (rxv - v0 != 0) begin fails++; $display("FAIL mid_no_rxv: %0d want 0", rxv - v0); end
        send16(16'h00FF);
        wait_rx16();
        tests++;
        if (rx_data !== 16'h00FF) begin fails++; $display("FAIL mid_next_rx: %h want 00ff", rx_data); end
        tick(4);
    endtask

    task automatic test_cfg_change();
        int c0, r0;
        cfg_div = 8'd1; cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_lb = 1;
        tick(2);
        c0 = cs_low; r0 = rises;
        send16(16'h0F0F);
        tick(3);
        cfg_cpol = 1'b1;
        cfg_div  = 8'd5;
        wait_rx16();
        tests++;
        if (rx_data !== 16'h0F0F) begin fails++; $display("FAIL cfg_rx1: %h want 0f0f", rx_data); end
        tick(3);
        tests += 3;
        if (cs_low - c0 != 68) begin fails++; $display("FAIL cfg_cs1: %0d want 68", cs_low - c0); end
        if (rises - r0 != 16) begin fails++; $display("FAIL cfg_rises1: %0d want 16", rises - r0); end
        if (sclk !== 1'b1) begin fails++; $display("FAIL cfg_idle_cpol: %b want 1", sclk); end
        c0 = cs_low;
        send16(16'h7E81);
        wait_rx16();
        tests++;
        if (rx_data !== 16'h7E81) begin fails++; $display("FAIL cfg_rx2: %h want 7e81", rx_data); end
        tick(3);
        tests += 2;
        if (cs_low - c0 != 204) begin fails++; $display("FAIL cfg_cs2: %0d want 204", cs_low - c0); end
        if (sclk !== 1'b1) begin fails++; $display("FAIL cfg_park2: %b want 1", sclk); end
        cfg_cpol = 1'b0;
        cfg_div  = 8'd1;
        tick(3);
    endtask

    task automatic test_w8();
        int c0, e0, v0, k;
        c0 = cs8; e0 = edges8; v0 = rxv8;
        k = 0;
        while (!d8_ready && k < 50) begin @(negedge clk); k++; end
        d8_tx = 8'h5A;
        d8_valid = 1'b1;
        tick(1);
        d8_valid = 1'b0;
        k = 0;
        while (!d8_rxv && k < 200) begin @(negedge clk); k++; end
        tests += 2;
        if (d8_rxv !== 1'b1) begin fails++; $display("FAIL w8_timeout: %b want 1", d8_rxv); end
        if (d8_rx !== 8'h5A) begin fails++; $display("FAIL w8_rx: %h want 5a", d8_rx); end
        tick(3);
        tests += 3;
        if (cs8 - c0 != 18) begin fails++; $display("FAIL w8_cs: %0d want 18", cs8 - c0); end
        if (edges8 - e0 != 16) begin fails++; $display("FAIL w8_edges: %0d want 16", edges8 - e0); end
        if (rxv8 - v0 != 1) begin fails++; $display("FAIL w8_rxv: %0d want 1", rxv8 - v0); end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_mode3_lsb();
        test_back_to_back();
        test_reset_mid();
        test_cfg_change();
        test_w8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_xfer_engine.md
SPI_XFER_ENGINE -- requirements
Module: spi_xfer_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bits per transfer word (4..32).
REQ-002 SHALL have parameter DIV_W, default 8, meaning width of the clock-divider config field.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning a synchronous, active-low reset.
REQ-005 SHALL have port cfg_div, input, DIV_W, meaning sclk half-period = cfg_div+1 clk cycles.
REQ-006 SHALL have ports cfg_cpol, cfg_cpha, cfg_lsb_first and cfg_loopback, each input, 1, meaning SPI mode, bit order and internal mosi->miso loopback.
REQ-007 SHALL have port tx_data, input, DATA_W, meaning the word to transmit.
REQ-008 SHALL have ports tx_valid (input, 1) and tx_ready (output, 1), meaning the transmit valid/ready handshake.
REQ-009 SHALL have ports rx_data (output, DATA_W) and rx_valid (output, 1), meaning the received word and its one-cycle strobe.
REQ-010 SHALL have port busy, output, 1, meaning a transfer is in progress.
REQ-011 SHALL have ports sclk (output, 1), mosi (output, 1), cs_n (output, 1) and miso (input, 1), meaning the SPI pins.

Function
REQ-012 SHALL implement FSM states IDLE, LEAD, XFER, TRAIL and GAP.
REQ-013 SHALL assert tx_ready only in IDLE; tx_valid&&tx_ready accepts the word and latches tx_data and all cfg_* inputs; later cfg_* changes SHALL not affect the accepted word.
REQ-014 SHALL, on accept, go to LEAD: cs_n=0 from the next cycle, held for one half-period; with CPHA=0, mosi presents the first bit for that whole half-period.
REQ-015 SHALL, in XFER, toggle sclk every half-period for exactly 2*DATA_W edges, then leave sclk at latched CPOL.
REQ-016 SHALL, for CPHA=0, sample on leading edges and shift mosi on trailing edges; for CPHA=1, shift on leading edges and sample on trailing edges.
REQ-017 SHALL send MSB first unless cfg_lsb_first=1; rx_data SHALL be assembled in the same order.
REQ-018 SHALL, when loopback=1, sample internal mosi instead of miso; the miso pin SHALL be ignored.
REQ-019 SHALL hold cs_n low for one half-period in TRAIL, then raise cs_n, pulse rx_valid for one cycle in that cycle, and update rx_data in the same cycle.
REQ-020 SHALL hold cs_n low for exactly (cfg_div+1)*(2*DATA_W+2) cycles per word.
REQ-021 SHALL, in GAP, hold cs_n high for cfg_div+1 cycles before IDLE, so back-to-back words are separated by a minimum gap.
REQ-022 SHALL assert busy from the cycle after accept until GAP exits.
REQ-023 SHALL drive sclk to live cfg_cpol while in IDLE.
REQ-024 SHALL hold rx_data stable between rx_valid pulses.

Reset
REQ-025 SHALL, with rst_n low at a clk edge, force: state=IDLE, cs_n=1, sclk=0, mosi=0, tx_ready=0, rx_valid=0, busy=0, rx_data=0, counters=0.
REQ-026 SHALL, on reset mid-transfer, abort with no rx_valid; tx_ready SHALL rise the first cycle after rst_n returns high.

Structure
REQ-027 SHALL place the state enum and the latched-config struct (cpol, cpha, lsb_first, loopback, div) in package spi_xfer_pkg.
REQ-028 SHALL use a single sub-module, spi_tick_gen, which produces the half-period tick from cfg_div and restarts on accept.
REQ-029 SHALL size the edge counter as $clog2(2*DATA_W+1) bits.

Verification
REQ-030 SHALL cover: DATA_W=16, mode 0, cfg_div=1, loopback=1, tx 16'hA55A -> rx_data=16'hA55A, one rx_valid, cs_n low 68 cycles, 16 rising sclk.
REQ-031 SHALL cover: mode 3, lsb_first=1, bench slave drives 16'h3C96 on miso -> rx_data=16'h3C96, mosi observed LSB first, sclk idles high.
REQ-032 SHALL cover: tx_valid held with 16'h1234 then 16'hBEEF, cfg_div=3 -> two rx_valid pulses and cs_n high exactly 4 cycles between words.
REQ-033 SHALL cover: rst_n low after 5 sclk edges -> next cycle cs_n=1, sclk=0, busy=0, no rx_valid; the next word 16'h00FF completes correctly.
REQ-034 SHALL cover: cfg_cpol/cfg_div toggled mid-transfer -> current word timing unchanged; the new cfg applies to the next word.
REQ-035 SHALL cover: DATA_W=8, cfg_div=0, loopback, tx 8'h5A -> sclk=clk/2, rx_data=8'h5A, cs_n low 18 cycles.
